// File: rtl/obi_bram_responder.sv
// OBI responder in front of BRAM port B, with an optional clear sweep after reset.
// Optional feature macro OBI_RANGE_CHECK_EN: out-of-window requests get an error response.
module obi_bram_responder #(
  parameter logic [31:0] ADDR_OFFSET    = 32'h00002600,
  parameter int          MEM_WORDS      = 6656,
  parameter int          BRAM_LAT       = 1,
  parameter logic [31:0] INIT_VALUE     = 32'h00000000,
  parameter bit          CLEAR_ON_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_clkb,
  output logic        mem_enb,
  output logic        mem_rstb,
  output logic [3:0]  mem_web,
  output logic [31:0] mem_addrb,
  output logic [31:0] mem_dinb,
  input  logic        mem_rstb_busy,
  input  logic [31:0] mem_doutb,
  output logic        busy_o
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state;
  logic [31:0]         clear_cnt;
  logic [BRAM_LAT-1:0] valid_pipe;
  logic [BRAM_LAT-1:0] we_pipe;
  logic [BRAM_LAT-1:0] err_pipe;
  logic                rvalid_q;
  logic [31:0]         rdata_q;
  logic                grant;
  logic                req_err;
  logic [31:0]         offset_addr;

  assign mem_clkb = clk;
  assign mem_rstb = reset;

  assign offset_addr = data_addr_i - ADDR_OFFSET;

`ifdef OBI_RANGE_CHECK_EN
  // Window end computed in 33 bits so a window touching 4 GiB cannot wrap.
  localparam logic [32:0] ADDR_END = {1'b0, ADDR_OFFSET} + (33'(MEM_WORDS) << 2);
  logic err_q;

  assign req_err    = (data_addr_i < ADDR_OFFSET) || ({1'b0, data_addr_i} >= ADDR_END);
  assign data_err_o = err_q & ~reset;
`else
  assign req_err    = 1'b0;
  assign data_err_o = 1'b0;
`endif

  assign grant         = ~reset & (state == RUN) & data_req_i & ~mem_rstb_busy;
  assign data_gnt_o    = grant;
  assign busy_o        = ~reset & (state == CLEAR);
  assign data_rvalid_o = rvalid_q & ~reset;
  assign data_rdata_o  = reset ? 32'h0 : rdata_q;

  // Port B is owned by the clear sweep while busy, otherwise by the granted request.
  always_comb begin
    mem_enb   = 1'b0;
    mem_web   = 4'h0;
    mem_addrb = 32'h0;
    mem_dinb  = 32'h0;
    if (busy_o) begin
      mem_enb   = 1'b1;
      mem_web   = 4'hF;
      mem_addrb = clear_cnt << 2;
      mem_dinb  = INIT_VALUE;
    end else if (grant && !req_err) begin
      mem_enb   = 1'b1;
      mem_web   = data_we_i ? data_be_i : 4'h0;
      mem_addrb = offset_addr & 32'hFFFF_FFFC;
      mem_dinb  = data_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR_ON_RESET ? CLEAR : RUN;
      clear_cnt  <= 32'h0;
      valid_pipe <= '0;
      we_pipe    <= '0;
      err_pipe   <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'h0;
`ifdef OBI_RANGE_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      if (state == CLEAR) begin
        if (clear_cnt == 32'(MEM_WORDS - 1)) begin
          state <= RUN;
        end else begin
          clear_cnt <= clear_cnt + 32'h1;
        end
      end

      valid_pipe[0] <= grant;
      we_pipe[0]    <= data_we_i;
      err_pipe[0]   <= req_err;
      for (int i = 1; i < BRAM_LAT; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
        we_pipe[i]    <= we_pipe[i-1];
        err_pipe[i]   <= err_pipe[i-1];
      end

      // The last pipeline stage lines up with mem_doutb for its read.
      rvalid_q <= valid_pipe[BRAM_LAT-1];
      if (!valid_pipe[BRAM_LAT-1]) begin
        rdata_q <= 32'h0;
      end else if (err_pipe[BRAM_LAT-1]) begin
        rdata_q <= 32'hDEADBEEF;
      end else if (we_pipe[BRAM_LAT-1]) begin
        rdata_q <= 32'h0;
      end else begin
        rdata_q <= mem_doutb;
      end
`ifdef OBI_RANGE_CHECK_EN
      err_q <= valid_pipe[BRAM_LAT-1] & err_pipe[BRAM_LAT-1];
`endif
    end
  end

endmodule
